inst_fetch_ctrl: RTL and testbench

//  Sequences the 32-bit instruction ROM (combinational read, ce/addr/data) for the MIPS core.

---
 rtl/cpu_defs.sv | 20 ++
 rtl/fetch_queue.sv | 51 +++++
 rtl/inst_fetch_ctrl.sv | 90 +++++++++
 tb/tb_inst_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared fetch-side definitions for the MIPS core.
// State encoding, word width and the queue entry layout.
package cpu_defs;

  localparam int INST_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT,
    S_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_queue.sv
// Small sync FIFO of {pc, inst} entries between ROM and decode.
// Push and pop may coincide even when full.
module fetch_queue
  import cpu_defs::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fetch_ent_t din,
  input  logic       pop,
  input  logic       flush,
  output fetch_ent_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(QDEPTH);

  fetch_ent_t     mem [QDEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; empty masks it downstream.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: PC, ROM strobe, fetch queue,
// redirect/halt/fault control and the decode handshake.
module inst_fetch_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_ce,
  output logic [31:0]       imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect_vld,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_req,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [31:0]       out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              halted,
  output logic              fault
);

  fetch_state_t state;
  logic [31:0]  pc;
  fetch_ent_t   head;
  fetch_ent_t   ent;
  logic         full;
  logic         empty;
  logic         pop;
  logic         fetch;

  assign out_vld = !empty && !redirect_vld;
  assign pop     = out_vld && out_rdy;
  assign fetch   = (state == S_RUN) && !redirect_vld &&
                   !halt_req && (!full || pop);

  assign imem_ce   = fetch;
  assign imem_addr = pc;
  assign out_pc    = out_vld ? head.pc   : '0;
  assign out_inst  = out_vld ? head.inst : '0;

  assign ent.pc   = pc;
  assign ent.inst = imem_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else if (state == S_IDLE) begin
      state <= S_RUN;
    end else if (redirect_vld) begin
      pc     <= redirect_pc;
      halted <= 1'b0;
      // Misaligned target parks the PC on the bad address.
      if (redirect_pc[1:0] != 2'b00) begin
        state <= S_FAULT;
        fault <= 1'b1;
      end else begin
        state <= S_RUN;
        fault <= 1'b0;
      end
    end else begin
      if (fetch)
        pc <= pc + 32'd4;
      if (state == S_RUN && halt_req) begin
        state  <= S_HALT;
        halted <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fetch),
    .din  (ent),
    .pop  (pop),
    .flush(redirect_vld),
    .dout (head),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_inst_fetch_ctrl;

  localparam int QD = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n, redir, halt, rdy;
  logic [31:0] rpc;
  logic        ce, vld, halted, fault;
  logic [31:0] addr, data, opc, oinst;

  logic        rst2;
  logic        ce2, vld2, halted2, fault2;
  logic [31:0] addr2, data2, opc2, oinst2;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [63:0] acc[$];
  logic [63:0] acc2[$];

  int          m_mode;
  logic [31:0] m_pc;
  logic [63:0] mq[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00: rom = 32'h0000_f025;
      32'h04: rom = 32'h241d_1000;
      32'h08: rom = 32'h8f99_0008;
      32'h20: rom = 32'h1080_0003;
      32'h24: rom = 32'h0000_0000;
      32'h30: rom = 32'h0000_0000;
      default: rom = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign data  = rom(addr);
  assign data2 = rom(addr2);

  inst_fetch_ctrl #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_ce(ce), .imem_addr(addr), .imem_data(data),
    .redirect_vld(redir), .redirect_pc(rpc), .halt_req(halt),
    .out_vld(vld), .out_rdy(rdy), .out_pc(opc), .out_inst(oinst),
    .halted(halted), .fault(fault)
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(QD)) dut2 (
    .clk(clk), .rst_n(rst2),
    .imem_ce(ce2), .imem_addr(addr2), .imem_data(data2),
    .redirect_vld(1'b0), .redirect_pc(32'h0), .halt_req(1'b0),
    .out_vld(vld2), .out_rdy(1'b1), .out_pc(opc2), .out_inst(oinst2),
    .halted(halted2), .fault(fault2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference model: advances one cycle per edge.
  always @(posedge clk or negedge rst_n) begin : model
    int   n;
    logic v, p, f;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_pc   = 32'h0;
      mq.delete();
    end else begin
      n = mq.size();
      v = (n > 0) && !redir;
      p = v && rdy;
      f = (m_mode == M_RUN) && !redir && !halt && (n < QD || p);
      if (m_mode == M_IDLE) begin
        m_mode = M_RUN;
      end else if (redir) begin
        mq.delete();
        m_pc   = rpc;
        m_mode = (rpc[1:0] != 2'b00) ? M_FAULT : M_RUN;
      end else begin
        if (p) void'(mq.pop_front());
        if (f) begin
          mq.push_back({m_pc, rom(m_pc)});
          m_pc = m_pc + 32'd4;
        end
        if (m_mode == M_RUN && halt) m_mode = M_HALT;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    int          n;
    logic        v, f;
    logic [63:0] h;
    n = mq.size();
    v = (n > 0) && !redir;
    f = (m_mode == M_RUN) && !redir && !halt && (n < QD || (v && rdy));
    h = v ? mq[0] : 64'h0;
    chk("m_ce",     {31'h0, ce},     {31'h0, f});
    chk("m_addr",   addr,            m_pc);
    chk("m_vld",    {31'h0, vld},    {31'h0, v});
    chk("m_pc",     opc,             h[63:32]);
    chk("m_inst",   oinst,           h[31:0]);
    chk("m_halted", {31'h0, halted}, {31'h0, m_mode == M_HALT});
    chk("m_fault",  {31'h0, fault},  {31'h0, m_mode == M_FAULT});
    if (rst_n && vld && rdy) acc.push_back({opc, oinst});
    if (rst2 && vld2) acc2.push_back({opc2, oinst2});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ent(input string nm, input logic [63:0] e,
                         input logic [31:0] p, input logic [31:0] i);
    chk({nm, "_pc"}, e[63:32], p);
    chk({nm, "_inst"}, e[31:0], i);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; rst2 = 1'b0;
    redir = 1'b0; rpc = 32'h0; halt = 1'b0; rdy = 1'b1;

    // Reset state and straight-line stream
    repeat (2) @(negedge clk);
    chk("rst_ce",   {31'h0, ce},  32'h0);
    chk("rst_addr", addr,         32'h0);
    chk("rst_vld",  {31'h0, vld}, 32'h0);
    chk("rst2_addr", addr2,       32'hFFFF_FFFC);
    step(); rst_n = 1'b1; acc.delete();
    @(negedge clk);
    chk("idle_ce", {31'h0, ce}, 32'h0);
    repeat (5) @(negedge clk);
    chk_ent("s0", acc[0], 32'h0, 32'h0000_f025);
    chk_ent("s1", acc[1], 32'h4, 32'h241d_1000);
    chk_ent("s2", acc[2], 32'h8, 32'h8f99_0008);

    // Backpressure from the first valid word
    step(); rst_n = 1'b0; rdy = 1'b0;
    step(); rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vld) begin ok = 1'b1; break; end
    end
    chk("vld_seen", {31'h0, ok}, 32'h1);
    repeat (4) @(negedge clk);
    chk("bp_addr", addr,         32'h8);
    chk("bp_ce",   {31'h0, ce},  32'h0);
    chk("bp_pc",   opc,          32'h0);
    step(); rdy = 1'b1; acc.delete();
    repeat (4) @(negedge clk);
    chk_ent("bp0", acc[0], 32'h0, 32'h0000_f025);
    chk_ent("bp2", acc[2], 32'h8, 32'h8f99_0008);

    // Redirect while full
    step(); rdy = 1'b0;
    repeat (3) step();
    redir = 1'b1; rpc = 32'h20; rdy = 1'b1;
    @(negedge clk);
    chk("rd_vld", {31'h0, vld}, 32'h0);
    chk("rd_ce",  {31'h0, ce},  32'h0);
    step(); redir = 1'b0; acc.delete();
    repeat (4) @(negedge clk);
    chk_ent("rd0", acc[0], 32'h20, 32'h1080_0003);
    chk_ent("rd1", acc[1], 32'h24, 32'h0);

    // Halt at pc 0x14, then resume at 0x30
    step(); redir = 1'b1; rpc = 32'h8;
    step(); redir = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (addr == 32'h14) begin ok = 1'b1; break; end
      step();
    end
    chk("pc14_seen", {31'h0, ok}, 32'h1);
    halt = 1'b1;
    step(); halt = 1'b0;
    @(negedge clk);
    chk("h_halted", {31'h0, halted}, 32'h1);
    chk("h_ce",     {31'h0, ce},     32'h0);
    chk("h_last",   acc[$][63:32],   32'h10);
    repeat (2) @(negedge clk);
    chk("h_drained", {31'h0, vld}, 32'h0);
    step(); redir = 1'b1; rpc = 32'h30;
    step(); redir = 1'b0; acc.delete();
    repeat (3) @(negedge clk);
    chk("r_halted", {31'h0, halted}, 32'h0);
    chk_ent("r0", acc[0], 32'h30, 32'h0);

    // Misaligned redirect, then recovery
    step(); redir = 1'b1; rpc = 32'h22;
    step(); redir = 1'b0;
    repeat (2) @(negedge clk);
    chk("f_fault", {31'h0, fault}, 32'h1);
    chk("f_ce",    {31'h0, ce},    32'h0);
    chk("f_vld",   {31'h0, vld},   32'h0);
    chk("f_addr",  addr,           32'h22);
    step(); redir = 1'b1; rpc = 32'h0;
    step(); redir = 1'b0; acc.delete();
    repeat (3) @(negedge clk);
    chk("f_clear", {31'h0, fault}, 32'h0);
    chk_ent("f0", acc[0], 32'h0, 32'h0000_f025);

    // Asynchronous reset in mid-stream
    @(negedge clk);
    chk("pre_vld", {31'h0, vld}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ce",   {31'h0, ce},  32'h0);
    chk("ar_addr", addr,         32'h0);
    chk("ar_vld",  {31'h0, vld}, 32'h0);
    chk("ar_pc",   opc,          32'h0);
    chk("ar_inst", oinst,        32'h0);

    // PC wrap from the top of the address space
    step(); rst2 = 1'b1;
    repeat (5) @(negedge clk);
    chk_ent("w0", acc2[0], 32'hFFFF_FFFC, 32'hC0DE_FFFC);
    chk_ent("w1", acc2[1], 32'h0, 32'h0000_f025);

    step();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
